// File: rtl/alarm_time_ctrl.sv
// alarm_time_ctrl: hh:mm:ss timekeeping, alarm setting and ring/snooze sequencer (snooze gated by ALARM_SNOOZE_EN).
module alarm_time_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       adjust,
  input  logic [3:0] en,
  input  logic       up,
  input  logic       down,
  input  logic       alarm_arm,
  input  logic       silence,
  input  logic       snooze,
  output logic [4:0] time_h,
  output logic [5:0] time_m,
  output logic [5:0] time_s,
  output logic [4:0] alarm_h,
  output logic [5:0] alarm_m,
  output logic       ringing,
  output logic       snoozing
);
  localparam int RW = $clog2(RING_SECS + 1);
`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  logic [SW-1:0] snz_cnt;
`else
  typedef enum logic {IDLE, RING} state_t;
`endif
  state_t state;
  logic [RW-1:0] ring_cnt;
  logic [4:0] h_n, ah_n;
  logic [5:0] m_n, s_n, am_n;
  logic acc, match;

  function automatic logic [4:0] step_h(input logic [4:0] v, input logic inc);
    return inc ? (v == 5'd23 ? 5'd0 : v + 5'd1) : (v == 5'd0 ? 5'd23 : v - 5'd1);
  endfunction

  function automatic logic [5:0] step_m(input logic [5:0] v, input logic inc);
    return inc ? (v == 6'd59 ? 6'd0 : v + 6'd1) : (v == 6'd0 ? 6'd59 : v - 6'd1);
  endfunction

  assign acc = adjust && (up ^ down) && $onehot(en);

  always_comb begin
    h_n  = time_h;
    m_n  = time_m;
    s_n  = time_s;
    ah_n = alarm_h;
    am_n = alarm_m;
    if (!adjust && tick_1hz) begin
      s_n = step_m(time_s, 1'b1);
      m_n = time_s == 6'd59 ? step_m(time_m, 1'b1) : time_m;
      h_n = (time_s == 6'd59 && time_m == 6'd59) ? step_h(time_h, 1'b1) : time_h;
    end else if (acc) begin
      h_n  = en[3] ? step_h(time_h, up) : time_h;
      m_n  = en[2] ? step_m(time_m, up) : time_m;
      s_n  = (en[3] || en[2]) ? 6'd0 : time_s;
      ah_n = en[1] ? step_h(alarm_h, up) : alarm_h;
      am_n = en[0] ? step_m(alarm_m, up) : alarm_m;
    end
  end

  // Compare against the time being written this edge so ringing rises with the :00 display.
  assign match = h_n == ah_n && m_n == am_n && s_n == 6'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_h   <= '0;
      time_m   <= '0;
      time_s   <= '0;
      alarm_h  <= '0;
      alarm_m  <= '0;
      state    <= IDLE;
      ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      time_h  <= h_n;
      time_m  <= m_n;
      time_s  <= s_n;
      alarm_h <= ah_n;
      alarm_m <= am_n;
      if (!alarm_arm || adjust) state <= IDLE;
      else if (state == IDLE) begin
        if (tick_1hz && match) begin
          state    <= RING;
          ring_cnt <= '0;
        end
      end else if (state == RING) begin
        if (silence) state <= IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          state   <= SNOOZE;
          snz_cnt <= SW'(SNOOZE_MIN * 60);
        end
`endif
        else if (tick_1hz) begin
          if (ring_cnt == RW'(RING_SECS - 1)) state <= IDLE;
          else ring_cnt <= ring_cnt + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      else if (silence) state <= IDLE;
      else if (tick_1hz) begin
        if (snz_cnt == SW'(1)) begin
          state    <= RING;
          ring_cnt <= '0;
        end else snz_cnt <= snz_cnt - SW'(1);
      end
`endif
    end
  end

  assign ringing = state == RING;
`ifdef ALARM_SNOOZE_EN
  assign snoozing = state == SNOOZE;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snoozing = 1'b0;
`endif
endmodule
